// File: rtl/vend_multi_controller_pkg.sv
// Shared types for the multi-slot vending controller: FSM state encoding and sizing helpers.
package vend_multi_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECTED = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_CHANGE   = 3'd3,
        ST_CONFIG   = 3'd4
    } vend_state_t;

    // Bits needed for a counter that runs from 0 to limit-1.
    function automatic int timer_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/vend_multi_controller_price_table.sv
// Per-slot price register file: synchronous write, asynchronous read, every slot reset to DEFAULT_PRICE.
module vend_multi_controller_price_table #(
    parameter int NUM_ITEMS     = 4,
    parameter int ID_W          = 2,
    parameter int CREDIT_W      = 8,
    parameter int DEFAULT_PRICE = 50
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                wr_en,
    input  logic [ID_W-1:0]     wr_id,
    input  logic [CREDIT_W-1:0] wr_price,
    input  logic [ID_W-1:0]     rd_id,
    output logic [CREDIT_W-1:0] rd_price
);

    logic [CREDIT_W-1:0] price_q [NUM_ITEMS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (!rstn) begin
                price_q[i] <= CREDIT_W'(DEFAULT_PRICE);
            end else if (wr_en && wr_id == ID_W'(i)) begin
                price_q[i] <= wr_price;
            end
        end
    end

    always_comb begin
        rd_price = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (rd_id == ID_W'(i)) rd_price = price_q[i];
        end
    end

endmodule

// File: rtl/vend_multi_controller.sv
// Vending controller: selection/credit FSM, coin accumulation, change return, idle timeout and price config.
module vend_multi_controller
    import vend_multi_controller_pkg::*;
#(
    parameter int NUM_ITEMS     = 4,
    parameter int ID_W          = 2,
    parameter int CREDIT_W      = 8,
    parameter int DEFAULT_PRICE = 50,
    parameter int TIMEOUT       = 1000
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cfg_mode,
    input  logic                 cfg_wr_en,
    input  logic [ID_W-1:0]      cfg_item_id,
    input  logic [CREDIT_W-1:0]  cfg_price,
    input  logic                 selection_valid,
    input  logic [ID_W-1:0]      selection_id,
    input  logic                 coin_valid,
    input  logic [CREDIT_W-1:0]  coin_value,
    input  logic                 cancel,
    input  logic [NUM_ITEMS-1:0] item_empty,
    output logic                 dispense_enable,
    output logic [ID_W-1:0]      dispense_id,
    output logic                 change_valid,
    output logic [CREDIT_W-1:0]  change_amount,
    output logic                 coin_reject,
    output logic                 sel_error,
    output logic [CREDIT_W-1:0]  credit,
    output logic                 busy,
    output vend_state_t          state_dbg
);

    // Strobes (selection_valid, coin_valid, cancel, cfg_wr_en) are one-cycle events sampled at the rising
    // edge with no back-pressure; every output pulse is registered and lasts exactly one cycle.
    localparam int ID_SPAN = 1 << ID_W;
    localparam int TMR_W   = timer_width(TIMEOUT);

    vend_state_t         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [ID_W-1:0]     sel_id_q, sel_id_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                dispense_enable_d, change_valid_d, coin_reject_d, sel_error_d, busy_d;
    logic [ID_W-1:0]     dispense_id_d;
    logic [CREDIT_W-1:0] change_amount_d;
    logic [CREDIT_W-1:0] price;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ok, sel_take, price_wr;
    logic [ID_SPAN-1:0]  slot_ok, id_exists;

    // Id-indexed masks so ids beyond NUM_ITEMS read as absent without out-of-range selects.
    for (genvar g = 0; g < ID_SPAN; g++) begin : g_slot
        if (g < NUM_ITEMS) begin : g_real
            assign slot_ok[g]   = !item_empty[g];
            assign id_exists[g] = 1'b1;
        end else begin : g_none
            assign slot_ok[g]   = 1'b0;
            assign id_exists[g] = 1'b0;
        end
    end

    assign price_wr = (state_q == ST_CONFIG) && cfg_wr_en && id_exists[cfg_item_id];

    vend_multi_controller_price_table #(
        .NUM_ITEMS    (NUM_ITEMS),
        .ID_W         (ID_W),
        .CREDIT_W     (CREDIT_W),
        .DEFAULT_PRICE(DEFAULT_PRICE)
    ) u_price_table (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (price_wr),
        .wr_id   (cfg_item_id),
        .wr_price(cfg_price),
        .rd_id   (sel_id_q),
        .rd_price(price)
    );

    always_comb begin
        state_d           = state_q;
        credit_d          = credit_q;
        sel_id_d          = sel_id_q;
        timer_d           = timer_q;
        dispense_enable_d = 1'b0;
        dispense_id_d     = dispense_id;
        change_valid_d    = 1'b0;
        change_amount_d   = change_amount;
        coin_reject_d     = 1'b0;
        sel_error_d       = 1'b0;
        sel_take          = 1'b0;

        coin_sum = {1'b0, credit_q} + {1'b0, coin_value};
        coin_ok  = coin_valid && !coin_sum[CREDIT_W] &&
                   ((state_q == ST_SELECTED) || (state_q == ST_IDLE && !cfg_mode));
        if (coin_valid && !coin_ok) coin_reject_d = 1'b1;
        if (coin_ok) credit_d = coin_sum[CREDIT_W-1:0];

        case (state_q)
            ST_IDLE: begin
                if (cfg_mode) begin
                    state_d = ST_CONFIG;
                end else begin
                    if (selection_valid) begin
                        if (slot_ok[selection_id]) begin
                            sel_take = 1'b1;
                            state_d  = ST_SELECTED;
                            sel_id_d = selection_id;
                            timer_d  = '0;
                        end else begin
                            sel_error_d = 1'b1;
                        end
                    end
                    if (!sel_take && cancel && credit_q != '0) state_d = ST_CHANGE;
                end
            end
            ST_SELECTED: begin
                // Cancel outranks a purchase completing in the same cycle.
                if (cancel) begin
                    state_d = ST_CHANGE;
                end else if (credit_q >= price) begin
                    state_d = ST_DISPENSE;
                end else if (coin_ok) begin
                    timer_d = '0;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    state_d = ST_CHANGE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_DISPENSE: begin
                dispense_enable_d = 1'b1;
                dispense_id_d     = sel_id_q;
                credit_d          = credit_q - price;
                state_d           = (credit_q != price) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                change_valid_d  = 1'b1;
                change_amount_d = credit_q;
                credit_d        = '0;
                state_d         = ST_IDLE;
            end
            ST_CONFIG: begin
                if (!cfg_mode) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q         <= ST_IDLE;
            credit_q        <= '0;
            sel_id_q        <= '0;
            timer_q         <= '0;
            dispense_enable <= 1'b0;
            dispense_id     <= '0;
            change_valid    <= 1'b0;
            change_amount   <= '0;
            coin_reject     <= 1'b0;
            sel_error       <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state_q         <= state_d;
            credit_q        <= credit_d;
            sel_id_q        <= sel_id_d;
            timer_q         <= timer_d;
            dispense_enable <= dispense_enable_d;
            dispense_id     <= dispense_id_d;
            change_valid    <= change_valid_d;
            change_amount   <= change_amount_d;
            coin_reject     <= coin_reject_d;
            sel_error       <= sel_error_d;
            busy            <= busy_d;
        end
    end

    assign credit    = credit_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_vend_multi_controller.sv
// Bench for vend_multi_controller: directed scenarios plus randomized purchases against a transaction model.
module tb_vend_multi_controller;
    import vend_multi_controller_pkg::*;

    localparam int NUM_ITEMS = 4;
    localparam int ID_W      = 2;
    localparam int CREDIT_W  = 8;
    localparam int TIMEOUT   = 16;

    logic                 clk;
    logic                 rstn;
    logic                 cfg_mode, cfg_wr_en;
    logic [ID_W-1:0]      cfg_item_id;
    logic [CREDIT_W-1:0]  cfg_price;
    logic                 selection_valid;
    logic [ID_W-1:0]      selection_id;
    logic                 coin_valid;
    logic [CREDIT_W-1:0]  coin_value;
    logic                 cancel;
    logic [NUM_ITEMS-1:0] item_empty;
    logic                 dispense_enable, change_valid, coin_reject, sel_error, busy;
    logic [ID_W-1:0]      dispense_id;
    logic [CREDIT_W-1:0]  change_amount, credit;
    vend_state_t          state_dbg;

    int checks = 0;
    int errors = 0;
    int rej_cnt = 0;
    int err_cnt = 0;
    int price_m [NUM_ITEMS];
    logic [ID_W-1:0]     obs_disp_q[$];
    logic [ID_W-1:0]     exp_disp_q[$];
    logic [CREDIT_W-1:0] obs_chg_q[$];
    logic [CREDIT_W-1:0] exp_chg_q[$];

    vend_multi_controller #(
        .NUM_ITEMS(NUM_ITEMS), .ID_W(ID_W), .CREDIT_W(CREDIT_W), .DEFAULT_PRICE(50), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rstn(rstn), .cfg_mode(cfg_mode), .cfg_wr_en(cfg_wr_en), .cfg_item_id(cfg_item_id),
        .cfg_price(cfg_price), .selection_valid(selection_valid), .selection_id(selection_id),
        .coin_valid(coin_valid), .coin_value(coin_value), .cancel(cancel), .item_empty(item_empty),
        .dispense_enable(dispense_enable), .dispense_id(dispense_id), .change_valid(change_valid),
        .change_amount(change_amount), .coin_reject(coin_reject), .sel_error(sel_error),
        .credit(credit), .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (dispense_enable) obs_disp_q.push_back(dispense_id);
        if (change_valid) obs_chg_q.push_back(change_amount);
        if (coin_reject) rej_cnt++;
        if (sel_error) err_cnt++;
    end

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_coin(input int v);
        coin_valid = 1'b1;
        coin_value = CREDIT_W'(v);
        tick(1);
        coin_valid = 1'b0;
    endtask

    task automatic drive_select(input int id);
        selection_valid = 1'b1;
        selection_id    = ID_W'(id);
        tick(1);
        selection_valid = 1'b0;
    endtask

    task automatic drive_cancel();
        cancel = 1'b1;
        tick(1);
        cancel = 1'b0;
    endtask

    task automatic write_price(input int id, input int p);
        cfg_wr_en   = 1'b1;
        cfg_item_id = ID_W'(id);
        cfg_price   = CREDIT_W'(p);
        tick(1);
        cfg_wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        tick(2);
    endtask

    task automatic clear_obs();
        obs_disp_q.delete();
        exp_disp_q.delete();
        obs_chg_q.delete();
        exp_chg_q.delete();
        rej_cnt = 0;
        err_cnt = 0;
    endtask

    function automatic int pick_coin();
        case ($urandom_range(0, 4))
            0:       return 5;
            1:       return 10;
            2:       return 20;
            3:       return 25;
            default: return 50;
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        tick(2);
        checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", state_dbg, ST_IDLE); end
        checks++; if (credit !== 8'd0) begin errors++; $display("FAIL reset_credit got %0d want 0", credit); end
        checks++; if ({dispense_enable, change_valid, coin_reject, sel_error, busy} !== 5'b0)
            begin errors++; $display("FAIL reset_flags got %b want 00000", {dispense_enable, change_valid, coin_reject, sel_error, busy}); end
        checks++; if ({dispense_id, change_amount} !== 10'd0)
            begin errors++; $display("FAIL reset_data got %h want 0", {dispense_id, change_amount}); end
        rstn = 1'b1;
        tick(1);
    endtask

    task automatic test_purchase_change();
        bit ok;
        clear_obs();
        drive_select(1);
        drive_coin(20);
        drive_coin(20);
        drive_coin(20);
        wait_idle(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL purchase_idle got busy want idle"); end
        checks++; if (obs_disp_q.size() != 1 || obs_disp_q[0] !== 2'd1)
            begin errors++; $display("FAIL purchase_disp got n=%0d id=%0d want n=1 id=1", obs_disp_q.size(), obs_disp_q[0]); end
        checks++; if (obs_chg_q.size() != 1 || obs_chg_q[0] !== 8'd10)
            begin errors++; $display("FAIL purchase_change got n=%0d amt=%0d want n=1 amt=10", obs_chg_q.size(), obs_chg_q[0]); end
        checks++; if (credit !== 8'd0) begin errors++; $display("FAIL purchase_credit got %0d want 0", credit); end
    endtask

    task automatic test_latency();
        bit ok;
        clear_obs();
        drive_coin(50);
        drive_select(2);
        tick(1);
        checks++; if (dispense_enable !== 1'b0) begin errors++; $display("FAIL lat_sel_early got %b want 0", dispense_enable); end
        tick(1);
        checks++; if (dispense_enable !== 1'b1 || dispense_id !== 2'd2)
            begin errors++; $display("FAIL lat_sel_pulse got en=%b id=%0d want en=1 id=2", dispense_enable, dispense_id); end
        tick(1);
        checks++; if (dispense_enable !== 1'b0) begin errors++; $display("FAIL lat_sel_width got %b want 0", dispense_enable); end
        wait_idle(10, ok);
        checks++; if (obs_chg_q.size() != 0 || credit !== 8'd0 || obs_disp_q.size() != 1)
            begin errors++; $display("FAIL lat_sel_after got chg=%0d credit=%0d disp=%0d want 0 0 1", obs_chg_q.size(), credit, obs_disp_q.size()); end
        clear_obs();
        drive_select(1);
        drive_coin(30);
        drive_coin(20);
        tick(1);
        checks++; if (dispense_enable !== 1'b0) begin errors++; $display("FAIL lat_coin_early got %b want 0", dispense_enable); end
        tick(1);
        checks++; if (dispense_enable !== 1'b1 || dispense_id !== 2'd1)
            begin errors++; $display("FAIL lat_coin_pulse got en=%b id=%0d want en=1 id=1", dispense_enable, dispense_id); end
        wait_idle(10, ok);
        checks++; if (!ok || obs_chg_q.size() != 0)
            begin errors++; $display("FAIL lat_coin_after got ok=%0d chg=%0d want 1 0", ok, obs_chg_q.size()); end
    endtask

    task automatic test_timeout();
        bit ok;
        clear_obs();
        drive_select(0);
        drive_coin(20);
        tick(10);
        checks++; if (busy !== 1'b1 || obs_chg_q.size() != 0)
            begin errors++; $display("FAIL timeout_early got busy=%b chg=%0d want 1 0", busy, obs_chg_q.size()); end
        wait_idle(4 * TIMEOUT, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_idle got busy want idle"); end
        checks++; if (obs_chg_q.size() != 1 || obs_chg_q[0] !== 8'd20 || obs_disp_q.size() != 0)
            begin errors++; $display("FAIL timeout_refund got chg=%0d amt=%0d disp=%0d want 1 20 0", obs_chg_q.size(), obs_chg_q[0], obs_disp_q.size()); end
    endtask

    task automatic test_sold_out();
        bit ok;
        clear_obs();
        item_empty = 4'b0100;
        drive_select(2);
        checks++; if (sel_error !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL soldout_err got err=%b busy=%b want 1 0", sel_error, busy); end
        tick(1);
        checks++; if (sel_error !== 1'b0 || err_cnt != 1)
            begin errors++; $display("FAIL soldout_pulse got err=%b cnt=%0d want 0 1", sel_error, err_cnt); end
        drive_select(0);
        drive_cancel();
        wait_idle(10, ok);
        checks++; if (!ok || obs_disp_q.size() != 0)
            begin errors++; $display("FAIL soldout_cancel got ok=%0d disp=%0d want 1 0", ok, obs_disp_q.size()); end
        item_empty = '0;
    endtask

    task automatic test_simultaneous();
        bit ok;
        clear_obs();
        drive_select(1);
        drive_coin(20);
        coin_valid = 1'b1; coin_value = 8'd10; cancel = 1'b1;
        tick(1);
        coin_valid = 1'b0; cancel = 1'b0;
        wait_idle(10, ok);
        checks++; if (obs_chg_q.size() != 1 || obs_chg_q[0] !== 8'd30 || obs_disp_q.size() != 0)
            begin errors++; $display("FAIL sim_coin_cancel got chg=%0d amt=%0d disp=%0d want 1 30 0", obs_chg_q.size(), obs_chg_q[0], obs_disp_q.size()); end
        clear_obs();
        drive_select(1);
        drive_coin(30);
        coin_valid = 1'b1; coin_value = 8'd20; cancel = 1'b1;
        tick(1);
        coin_valid = 1'b0; cancel = 1'b0;
        wait_idle(10, ok);
        checks++; if (obs_chg_q.size() != 1 || obs_chg_q[0] !== 8'd50 || obs_disp_q.size() != 0)
            begin errors++; $display("FAIL sim_complete_cancel got chg=%0d amt=%0d disp=%0d want 1 50 0", obs_chg_q.size(), obs_chg_q[0], obs_disp_q.size()); end
    endtask

    task automatic test_config();
        bit ok;
        clear_obs();
        cfg_mode = 1'b1;
        tick(1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cfg_enter got busy=%b want 1", busy); end
        write_price(3, 30);
        drive_coin(10);
        drive_select(1);
        drive_cancel();
        tick(2);
        cfg_mode = 1'b0;
        tick(1);
        checks++; if (busy !== 1'b0 || rej_cnt != 1 || obs_disp_q.size() != 0 || credit !== 8'd0)
            begin errors++; $display("FAIL cfg_exit got busy=%b rej=%0d disp=%0d credit=%0d want 0 1 0 0", busy, rej_cnt, obs_disp_q.size(), credit); end
        drive_select(3);
        drive_coin(30);
        wait_idle(10, ok);
        checks++; if (obs_disp_q.size() != 1 || obs_disp_q[0] !== 2'd3 || obs_chg_q.size() != 0)
            begin errors++; $display("FAIL cfg_price got disp=%0d id=%0d chg=%0d want 1 3 0", obs_disp_q.size(), obs_disp_q[0], obs_chg_q.size()); end
    endtask

    task automatic test_overflow_and_reset();
        bit ok;
        clear_obs();
        repeat (5) drive_coin(50);
        checks++; if (credit !== 8'd250) begin errors++; $display("FAIL ovf_accum got %0d want 250", credit); end
        drive_coin(10);
        checks++; if (coin_reject !== 1'b1 || credit !== 8'd250)
            begin errors++; $display("FAIL ovf_reject got rej=%b credit=%0d want 1 250", coin_reject, credit); end
        drive_cancel();
        wait_idle(10, ok);
        checks++; if (obs_chg_q.size() != 1 || obs_chg_q[0] !== 8'd250)
            begin errors++; $display("FAIL ovf_refund got n=%0d amt=%0d want 1 250", obs_chg_q.size(), obs_chg_q[0]); end
        clear_obs();
        drive_select(0);
        drive_coin(20);
        rstn = 1'b0;
        tick(1);
        checks++; if ({dispense_enable, change_valid, coin_reject, sel_error, busy} !== 5'b0 || credit !== 8'd0)
            begin errors++; $display("FAIL midreset_out got flags=%b credit=%0d want 0 0", {dispense_enable, change_valid, coin_reject, sel_error, busy}, credit); end
        rstn = 1'b1;
        tick(3);
        checks++; if (obs_disp_q.size() != 0 || obs_chg_q.size() != 0)
            begin errors++; $display("FAIL midreset_pulses got disp=%0d chg=%0d want 0 0", obs_disp_q.size(), obs_chg_q.size()); end
        drive_select(3);
        drive_coin(30);
        tick(3);
        checks++; if (obs_disp_q.size() != 0 || busy !== 1'b1)
            begin errors++; $display("FAIL midreset_price got disp=%0d busy=%b want 0 1", obs_disp_q.size(), busy); end
        drive_coin(20);
        wait_idle(10, ok);
        checks++; if (obs_disp_q.size() != 1 || obs_disp_q[0] !== 2'd3 || obs_chg_q.size() != 0)
            begin errors++; $display("FAIL midreset_buy got disp=%0d id=%0d chg=%0d want 1 3 0", obs_disp_q.size(), obs_disp_q[0], obs_chg_q.size()); end
    endtask

    task automatic test_random();
        bit ok;
        int slot, sum, n, cancel_after;
        bit want_cancel, cancelled;
        cfg_mode = 1'b1;
        tick(1);
        for (int i = 0; i < NUM_ITEMS; i++) begin
            price_m[i] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(5, 200));
            write_price(i, price_m[i]);
        end
        cfg_mode = 1'b0;
        tick(1);
        for (int t = 0; t < 14; t++) begin
            clear_obs();
            slot         = int'($urandom_range(0, NUM_ITEMS - 1));
            want_cancel  = (price_m[slot] > 0) && ($urandom_range(0, 3) == 0);
            cancel_after = int'($urandom_range(0, 2));
            cancelled    = 1'b0;
            sum = 0;
            n   = 0;
            drive_select(slot);
            tick(int'($urandom_range(0, 2)));
            while (sum < price_m[slot]) begin
                if (want_cancel && n == cancel_after) begin
                    cancelled = 1'b1;
                    break;
                end
                drive_coin(pick_coin());
                sum += int'(coin_value);
                n++;
                if (sum < price_m[slot]) tick(int'($urandom_range(0, 2)));
            end
            if (cancelled) begin
                drive_cancel();
                exp_chg_q.push_back(CREDIT_W'(sum));
            end else begin
                exp_disp_q.push_back(ID_W'(slot));
                if (sum > price_m[slot]) exp_chg_q.push_back(CREDIT_W'(sum - price_m[slot]));
            end
            wait_idle(20, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_idle got busy want idle", t); end
            checks++; if (obs_disp_q.size() != exp_disp_q.size() || obs_chg_q.size() != exp_chg_q.size())
                begin errors++; $display("FAIL rnd%0d_count got disp=%0d chg=%0d want %0d %0d", t, obs_disp_q.size(), obs_chg_q.size(), exp_disp_q.size(), exp_chg_q.size()); end
            for (int k = 0; k < exp_disp_q.size() && k < obs_disp_q.size(); k++) begin
                checks++; if (obs_disp_q[k] !== exp_disp_q[k])
                    begin errors++; $display("FAIL rnd%0d_disp got %0d want %0d", t, obs_disp_q[k], exp_disp_q[k]); end
            end
            for (int k = 0; k < exp_chg_q.size() && k < obs_chg_q.size(); k++) begin
                checks++; if (obs_chg_q[k] !== exp_chg_q[k])
                    begin errors++; $display("FAIL rnd%0d_change got %0d want %0d", t, obs_chg_q[k], exp_chg_q[k]); end
            end
            checks++; if (credit !== 8'd0) begin errors++; $display("FAIL rnd%0d_credit got %0d want 0", t, credit); end
        end
    endtask

    initial begin
        rstn = 1'b0; cfg_mode = 1'b0; cfg_wr_en = 1'b0; cfg_item_id = '0; cfg_price = '0;
        selection_valid = 1'b0; selection_id = '0; coin_valid = 1'b0; coin_value = '0;
        cancel = 1'b0; item_empty = '0;
        tick(1);
        test_reset();
        test_purchase_change();
        test_latency();
        test_timeout();
        test_sold_out();
        test_simultaneous();
        test_config();
        test_overflow_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
